// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned 32x32->64 shift-add multiplier controller.
// Borrows the shared execute-stage adder for one add per iteration and has no adder of its own.
module seq_mult_ctrl #(
    parameter logic [2:0] OP_ADD = 3'b101,
    parameter int         ITER   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        add_en,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [2:0]  add_op,
    input  logic [31:0] add_result,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_mcand;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   w_sum;
    logic                w_carry;
    logic                w_last;

    // The shared unit exports no carry, so recover it from the operand and sum MSBs.
    function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    endfunction

    assign w_last = (r_cnt == CNT_W'(ITER - 1));

    always_comb begin
        w_sum   = r_hi;
        w_carry = 1'b0;
        if (r_lo[0]) begin
            w_sum   = add_result;
            w_carry = carry_out(r_hi[DATA_W-1], r_mcand[DATA_W-1], add_result[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Load on accepted start, then shift {carry, sum, lo} right one bit per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= op_a;
                        r_lo    <= op_b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_hi  <= {w_carry, w_sum[DATA_W-1:1]};
                    r_lo  <= {w_sum[0], r_lo[DATA_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign add_en  = (r_state == S_RUN);
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign add_op  = add_en ? OP_ADD : 3'b000;
    assign add_a   = r_hi;
    assign add_b   = r_mcand;
    assign product = {r_hi, r_lo};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and random bench for seq_mult_ctrl with a behavioural stand-in for the shared adder.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        add_en;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [2:0]  add_op;
    logic [31:0] add_result;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    assign add_result = (add_op == 3'b101) ? (add_a + add_b) : 32'h0;

    seq_mult_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_op(add_op),
        .add_result(add_result), .busy(busy), .done(done), .product(product)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge, then follow the run to its done pulse and score the product.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit full);
        int n;
        bit ctl_ok;
        logic [63:0] exp;
        start = 1'b1; op_a = a; op_b = b;
        sb_q.push_back({32'h0, a} * {32'h0, b});
        tick();
        start = 1'b0;
        op_a = ~a; op_b = ~b;
        n = 0; ctl_ok = 1'b1;
        while (!done && n < 40) begin
            if (!(busy && add_en && add_op == 3'b101 && add_b == a)) ctl_ok = 1'b0;
            tick();
            n++;
        end
        exp = sb_q.pop_front();
        if (full) begin
            chk("run_ctl", {63'h0, ctl_ok}, 64'h1);
            chk("run_len", 64'(n), 64'd32);
            chk("done_outs", {60'h0, done, busy, add_en, |add_op}, {60'h0, 4'b1000});
        end
        chk("product", product, exp);
        tick();
        if (full) chk("done_pulse", {62'h0, done, busy}, 64'h0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        #12;
        chk("rst_outs", {60'h0, busy, done, add_en, |add_op}, 64'h0);
        chk("rst_product", product, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        do_mult(32'd3, 32'd5, 1'b1);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_mult(32'h8000_0000, 32'd2, 1'b1);
        repeat (3) tick();
        chk("prod_hold", product, 64'h0000_0001_0000_0000);
        do_mult(32'h0, 32'hDEAD_BEEF, 1'b1);

        // Start held high: second operands only take effect after DONE.
        start = 1'b1; op_a = 32'd3; op_b = 32'd5;
        tick();
        op_a = 32'd100; op_b = 32'd200;
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("cont_len", 64'(n), 64'd32);
        chk("cont_prod", product, 64'd15);
        tick();
        chk("cont_idle", {62'h0, busy, done}, 64'h0);
        tick();
        start = 1'b0;
        chk("cont_accept", {63'h0, busy}, 64'h1);
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("cont_prod2", product, 64'd20000);
        tick();

        // Reset mid-RUN.
        start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst_outs", {60'h0, busy, done, add_en, |add_op}, 64'h0);
        chk("midrst_product", product, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin tick(); if (done || busy) seen = 1'b1; end
        chk("midrst_nodone", {63'h0, seen}, 64'h0);
        do_mult(32'd7, 32'd9, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra[31] = 1'b1;
            do_mult(ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Multi-cycle unsigned 32x32->64 shift-add multiplier controller.
- Owns no adder of its own. It time-shares the team's 32-bit combinational add/sub/slt unit through an external port pair, and the top level muxes that unit's inputs on `add_en`.
- Sequences 32 add/shift iterations and returns a registered 64-bit product with a start/busy/done handshake.
- Sits beside the ALU in the execute stage and serves multiply instructions.

Parameters:
- OP_ADD, 3'b101, alu_op code the shared unit decodes as plain addition (carry-in 0, sum routed to Result).
- ITER, 32, number of iterations; equals operand width; counter width is clog2(ITER)+1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  32  multiplicand, captured on accepted start.
- op_b  input  32  multiplier, captured on accepted start.
- add_en  output  1  high while the controller owns the shared adder (RUN only).
- add_a  output  32  adder operand A = hi product register.
- add_b  output  32  adder operand B = captured multiplicand.
- add_op  output  3  OP_ADD while add_en, else 3'b000.
- add_result  input  32  combinational sum from the shared unit, same cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- product  output  64  {hi, lo}; valid when done, held until next accepted start.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state=IDLE, hi=0, lo=0, mcand=0, cnt=0.
  - busy=0, done=0, add_en=0, add_op=000, product=0.
  - An in-flight multiply is discarded with no done pulse.
- IDLE:
  - On start=1: mcand<=op_a, lo<=op_b, hi<=0, cnt<=0, go to RUN.
  - On start=0: hold all registers; product keeps its last value.
- RUN (exactly ITER cycles, cnt 0..ITER-1):
  - add_en=1, add_a=hi, add_b=mcand, add_op=OP_ADD.
  - If lo[0]=1:
    - s=add_result.
    - c=(hi[31]&mcand[31]) | ((hi[31]^mcand[31]) & ~s[31]) (carry rebuilt locally; the shared unit exports none).
  - If lo[0]=0: s=hi, c=0.
  - Update: hi<={c, s[31:1]}, lo<={s[0], lo[31:1]}, cnt<=cnt+1.
  - When cnt=ITER-1 is processed, go to DONE.
  - start is ignored throughout.
- DONE (1 cycle):
  - done=1, busy=0, add_en=0.
  - start is ignored.
  - Go to IDLE next cycle.
- Latency:
  - Accepting edge -> 32 RUN cycles -> done asserted on the 33rd cycle after acceptance.
  - Minimum start-to-start spacing is 34 cycles.
- Outputs busy, done and add_en decode directly from state registers (glitch-free, no combinational path from start).
- Arithmetic is unsigned; the product never overflows 64 bits.
- Operand zero needs no special case: it still takes the full 32 iterations.
- op_a/op_b may change after acceptance without effect.

Test Plan:
- start with op_a=3, op_b=5 -> busy for 32 cycles, add_en/add_op=101 during RUN, done pulse once, product=0x0000_0000_0000_000F.
- op_a=0xFFFF_FFFF, op_b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001; exercises carry reconstruction on every iteration.
- op_a=0x8000_0000, op_b=2, then op_a=0, op_b=0xDEAD_BEEF back-to-back:
  - first product=0x0000_0001_0000_0000;
  - second product=0 after 32 cycles;
  - product holds between runs.
- start asserted continuously plus new operands mid-RUN -> only the first operands are used; the second start is accepted only in IDLE after the DONE cycle.
- reset pulsed at RUN cycle 10 -> all outputs 0 immediately (asynchronous), no done; a subsequent start with 7x9 gives 63.
- Random 1000-pair unsigned compare against a 64-bit reference model, with the shared adder stubbed behaviourally for OP_ADD.
